// File: rtl/uart_rx_core_if.sv
// Byte-side and pin-side signals of the UART receiver, grouped for port connection.
// The core takes the slave view; the transmitter/consumer side takes the master view.
interface uart_rx_core_if;
    logic       uart_rxd;
    logic [7:0] rout;
    logic       rout_en;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        output uart_rxd,
        input  rout,
        input  rout_en,
        input  frame_err,
        input  rx_busy
    );

    modport slave (
        input  uart_rxd,
        output rout,
        output rout_en,
        output frame_err,
        output rx_busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop input synchronizer and mid-bit sampling FSM that emits
// one-cycle byte strobes, framing-error strobes and a line-busy flag.
module uart_rx_core #(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_core_if.slave  bus
);
    localparam int unsigned HALF_DIV = CLK_DIV / 2;
    localparam int unsigned CW       = $clog2(CLK_DIV);

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_DIV - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_STOP    = 3'd3;
    localparam logic [2:0] S_BRKWAIT = 3'd4;

    logic          sync1_q, sync2_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rout_q, rout_d;
    logic          rout_en_q, rout_en_d;
    logic          frame_err_q, frame_err_d;
    logic          rxd_s;

    assign rxd_s = sync2_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        rout_d      = rout_q;
        rout_en_d   = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rxd_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                // Re-check the start bit at its midpoint to reject line glitches.
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rxd_s) begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    shift_d = {rxd_s, shift_q[7:1]};
                    cnt_d   = '0;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        rout_d    = shift_q;
                        rout_en_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BRKWAIT;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_BRKWAIT: begin
                if (rxd_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rout_q      <= '0;
            rout_en_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= bus.uart_rxd;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rout_q      <= rout_d;
            rout_en_q   <= rout_en_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.rout      = rout_q;
    assign bus.rout_en   = rout_en_q;
    assign bus.frame_err = frame_err_q;
    assign bus.rx_busy   = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: a serial driver queues the expected strobe per frame,
// and an independent monitor pops and compares whenever rout_en or frame_err fires.
module tb_uart_rx_core;
    localparam int unsigned CLK_DIV = 16;
    localparam int unsigned HALF    = CLK_DIV / 2;
    localparam longint      LAT     = 2 + HALF + 9 * CLK_DIV + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_core_if bus ();

    uart_rx_core #(.CLK_DIV(CLK_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        longint     due;
    } exp_t;

    exp_t       exp_q[$];
    longint     cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_rout = 8'h00;
    logic       prev_strobe = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            bus.uart_rxd = v;
        end
    endtask

    // Bit period given in hundredths of a clock so rates within +/-4% can be produced.
    task automatic send(input logic [7:0] d, input int p100, input logic stop_v);
        logic [9:0] bits;
        int         prev;
        int         nxt;
        exp_t       e;
        bits = {stop_v, d, 1'b0};
        prev = 0;
        for (int j = 0; j < 10; j++) begin
            nxt = ((j + 1) * p100 + 50) / 100;
            for (int i = prev; i < nxt; i++) begin
                @(negedge clk);
                bus.uart_rxd = bits[j];
                if (j == 0 && i == 0) begin
                    e.is_err = !stop_v;
                    e.data   = d;
                    e.due    = cyc + LAT;
                    exp_q.push_back(e);
                end
            end
            prev = nxt;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_strobe = 1'b0;
        end else begin
            if (bus.rout_en || bus.frame_err) begin
                chk("strobe_width", {63'd0, prev_strobe}, 64'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got rout_en=%0b frame_err=%0b rout=%0h expected no strobe at cycle %0d",
                             bus.rout_en, bus.frame_err, bus.rout, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_kind", {62'd0, bus.rout_en, bus.frame_err},
                        e.is_err ? 64'd1 : 64'd2);
                    chk("strobe_cycle", cyc, e.due);
                    if (!e.is_err) begin
                        model_rout = e.data;
                    end
                    chk(e.is_err ? "rout_held" : "rout_data", bus.rout, model_rout);
                end
            end
            prev_strobe = bus.rout_en || bus.frame_err;
        end
    end

    initial begin
        int w;
        bus.uart_rxd = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_rout", bus.rout, 8'h00);
        chk("reset_rout_en", bus.rout_en, 0);
        chk("reset_frame_err", bus.frame_err, 0);
        chk("reset_rx_busy", bus.rx_busy, 0);
        rst = 1'b0;
        drive(1'b1, 5);

        send(8'h67, 1600, 1'b1);
        drive(1'b1, 20);
        chk("idle_after_g", bus.rx_busy, 0);
        chk("rout_g", bus.rout, 8'h67);

        send(8'h77, 1600, 1'b1);
        send(8'h30, 1600, 1'b1);
        send(8'h64, 1600, 1'b1);
        drive(1'b1, 20);

        drive(1'b0, 4);
        chk("glitch_busy", bus.rx_busy, 1);
        drive(1'b1, 9);
        chk("glitch_idle", bus.rx_busy, 0);
        send(8'h71, 1600, 1'b1);
        drive(1'b1, 20);

        send(8'h0d, 1600, 1'b0);
        drive(1'b0, 50);
        chk("break_busy", bus.rx_busy, 1);
        drive(1'b1, 5);
        chk("break_released", bus.rx_busy, 0);
        chk("break_rout_kept", bus.rout, 8'h71);
        send(8'h6a, 1600, 1'b1);
        drive(1'b1, 20);

        // Start of 0x55 plus four data bits, then abort with reset and an idle line.
        drive(1'b0, CLK_DIV);
        drive(1'b1, CLK_DIV);
        drive(1'b0, CLK_DIV);
        drive(1'b1, CLK_DIV);
        drive(1'b0, CLK_DIV);
        @(negedge clk);
        rst = 1'b1;
        bus.uart_rxd = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_rout = 8'h00;
        chk("midreset_rout", bus.rout, 8'h00);
        chk("midreset_rout_en", bus.rout_en, 0);
        chk("midreset_frame_err", bus.frame_err, 0);
        chk("midreset_rx_busy", bus.rx_busy, 0);
        drive(1'b1, 200);
        send(8'haa, 1600, 1'b1);
        drive(1'b1, 20);

        send(8'h3c, 1664, 1'b1);
        send(8'h3c, 1536, 1'b1);
        drive(1'b1, 10);

        for (int n = 0; n < 24; n++) begin
            send(8'($urandom_range(0, 255)), int'($urandom_range(1536, 1664)), 1'b1);
            drive(1'b1, int'($urandom_range(0, 12)));
        end

        w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        drive(1'b1, 5);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
